instr_encoder: RTL and testbench

Instruction encoder and writer: accepts decoded instruction descriptors (class, register indices, funct fields, immediate) on a valid/ready input. It packs each descriptor into a 32-bit RV32I word using the same opcode set the core's control unit decodes, and buffers the words in a small FIFO. It emits them as sequentially addressed writes toward instruction memory. It is used by the test-program loader and the self-check infrastructure to build programs in hardware.

---
 rtl/riscv_isa_pkg.sv | 47 ++++
 rtl/sync_fifo.sv | 66 ++++++
 rtl/instr_encoder.sv | 145 ++++++++++++++
 tb/tb_instr_encoder.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_isa_pkg.sv
// ---------------------------------------------------------------------------
// riscv_isa_pkg : RV32I opcodes, descriptor classes and immediate formats
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package riscv_isa_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    CLS_R       = 3'd0,
    CLS_LOAD    = 3'd1,
    CLS_STORE   = 3'd2,
    CLS_BRANCH  = 3'd3,
    CLS_OPIMM   = 3'd4,
    CLS_JAL     = 3'd5,
    CLS_JALR    = 3'd6,
    CLS_ILLEGAL = 3'd7
  } instr_class_t;

  typedef enum logic [1:0] {
    IMM_I = 2'd0,
    IMM_S = 2'd1,
    IMM_B = 2'd2,
    IMM_J = 2'd3
  } imm_fmt_t;

  // True when v, read as signed 32-bit, is representable in 'bits' signed bits.
  function automatic logic fits_signed(input logic [31:0] v, input int bits);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i >= bits - 1 && v[i] != v[31]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo : single-clock FIFO, registered occupancy, no fall-through
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == (PTR_W+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + (PTR_W+1)'(1);
    else if (!do_push && do_pop) count_d = count_q - (PTR_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder : packs instruction descriptors into RV32I words and emits
//                 them as sequentially addressed instruction-memory writes
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module instr_encoder
  import riscv_isa_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter int          ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_class,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_rs1,
  input  logic [4:0]               in_rs2,
  input  logic [2:0]               in_funct3,
  input  logic [6:0]               in_funct7,
  input  logic [31:0]              in_imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [ADDR_W-1:0]        out_addr,
  output logic                     err_pulse,
  output logic                     err_sticky,
  output logic [$clog2(DEPTH):0]   count
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef struct packed {
    logic [31:0] word;
    logic        bad;
  } enc_t;

  function automatic enc_t encode(input logic [2:0] cls_raw, input logic [4:0] rd,
                                  input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [31:0] imm);
    enc_t         r;
    imm_fmt_t     fmt;
    logic         has_imm;
    instr_class_t cls;
    cls     = instr_class_t'(cls_raw);
    r.word  = '0;
    r.bad   = 1'b0;
    fmt     = IMM_I;
    has_imm = 1'b1;
    case (cls)
      CLS_R: begin
        r.word  = {f7, rs2, rs1, f3, rd, OPC_OP};
        has_imm = 1'b0;
      end
      CLS_LOAD:   r.word = {imm[11:0], rs1, f3, rd, OPC_LOAD};
      CLS_OPIMM:  r.word = {imm[11:0], rs1, f3, rd, OPC_OPIMM};
      CLS_JALR:   r.word = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
      CLS_STORE: begin
        r.word = {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
        fmt    = IMM_S;
      end
      CLS_BRANCH: begin
        r.word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
        fmt    = IMM_B;
      end
      CLS_JAL: begin
        r.word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
        fmt    = IMM_J;
      end
      default: begin
        r.bad   = 1'b1;
        has_imm = 1'b0;
      end
    endcase
    if (has_imm) begin
      case (fmt)
        IMM_I, IMM_S: r.bad = !fits_signed(imm, 12);
        IMM_B:        r.bad = !fits_signed(imm, 13) || imm[0];
        IMM_J:        r.bad = !fits_signed(imm, 21) || imm[0];
        default:      r.bad = 1'b1;
      endcase
    end
    return r;
  endfunction

  enc_t              enc;
  logic              accept, push, pop;
  logic              fifo_full, fifo_empty;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_pulse_q, err_pulse_d;
  logic              err_sticky_q, err_sticky_d;

  assign in_ready   = !fifo_full && !rst;
  assign out_valid  = !fifo_empty;
  assign out_addr   = addr_q;
  assign err_pulse  = err_pulse_q;
  assign err_sticky = err_sticky_q;

  // Rejected descriptors still complete the handshake but never reach the FIFO.
  always_comb begin
    enc          = encode(in_class, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
    accept       = in_valid && in_ready;
    push         = accept && !enc.bad;
    pop          = out_valid && out_ready;
    addr_d       = addr_q;
    if (pop) addr_d = addr_q + ADDR_W'(1);
    err_pulse_d  = accept && enc.bad;
    err_sticky_d = err_sticky_q || err_pulse_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q       <= BASE;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      err_pulse_q  <= err_pulse_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (enc.word),
    .pop       (pop),
    .pop_data  (out_instr),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder : directed and random checks of instr_encoder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_instr_encoder;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_class;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic        err_pulse;
  logic        err_sticky;
  logic [2:0]  count;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_encoder #(
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_class   (in_class),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_funct3  (in_funct3),
    .in_funct7  (in_funct7),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_addr   (out_addr),
    .err_pulse  (err_pulse),
    .err_sticky (err_sticky),
    .count      (count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  // Reference encoder: field placement done with shifts and masks on plain integers.
  function automatic logic [31:0] ref_enc(input int cls, input int rd, input int rs1,
                                          input int rs2, input int f3, input int f7,
                                          input int imm, output bit bad);
    logic [31:0] u, w;
    u = imm;
    w = '0;
    bad = 0;
    case (cls)
      0: w = (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
             | (32'(rd) << 7) | 32'h33;
      1, 4, 6: begin
        w = ((u & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(rd) << 7)
            | ((cls == 6) ? 32'h0 : (32'(f3) << 12))
            | ((cls == 1) ? 32'h03 : (cls == 4) ? 32'h13 : 32'h67);
        bad = (imm < -2048) || (imm > 2047);
      end
      2: begin
        w = (((u >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
            | (32'(f3) << 12) | ((u & 32'h1F) << 7) | 32'h23;
        bad = (imm < -2048) || (imm > 2047);
      end
      3: begin
        w = (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25) | (32'(rs2) << 20)
            | (32'(rs1) << 15) | (32'(f3) << 12) | (((u >> 1) & 32'hF) << 8)
            | (((u >> 11) & 32'h1) << 7) | 32'h63;
        bad = (imm < -4096) || (imm > 4095) || (u[0] == 1'b1);
      end
      5: begin
        w = (((u >> 20) & 32'h1) << 31) | (((u >> 1) & 32'h3FF) << 21)
            | (((u >> 11) & 32'h1) << 20) | (((u >> 12) & 32'hFF) << 12)
            | (32'(rd) << 7) | 32'h6F;
        bad = (imm < -(1 << 20)) || (imm >= (1 << 20)) || (u[0] == 1'b1);
      end
      default: bad = 1;
    endcase
    return w;
  endfunction

  // Scoreboard: queue of expected words, address and error-flag model.
  logic [31:0] exp_q[$];
  int          exp_addr   = 0;
  bit          exp_err    = 0;
  bit          exp_sticky = 0;
  bit          mon_on     = 0;

  always @(negedge clk) begin
    bit          bad;
    logic [31:0] w;
    if (rst) begin
      exp_q.delete();
      exp_addr   = 0;
      exp_err    = 0;
      exp_sticky = 0;
      mon_on     = 1;
    end else if (mon_on) begin
      check("mon_count", {29'b0, count}, exp_q.size());
      check("mon_in_ready", {31'b0, in_ready}, {31'b0, exp_q.size() < DEPTH});
      check("mon_out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
      check("mon_err_pulse", {31'b0, err_pulse}, {31'b0, exp_err});
      check("mon_err_sticky", {31'b0, err_sticky}, {31'b0, exp_sticky});
      if (out_valid && out_ready && exp_q.size() != 0) begin
        check("mon_out_instr", out_instr, exp_q[0]);
        check("mon_out_addr", {30'b0, out_addr}, exp_addr);
        void'(exp_q.pop_front());
        exp_addr = (exp_addr + 1) % (1 << ADDR_W);
      end
      exp_err = 0;
      if (in_valid && in_ready) begin
        w = ref_enc(int'(in_class), int'(in_rd), int'(in_rs1), int'(in_rs2),
                    int'(in_funct3), int'(in_funct7), $signed(in_imm), bad);
        if (bad) begin
          exp_err    = 1;
          exp_sticky = 1;
        end else begin
          exp_q.push_back(w);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_desc(input int cls, input int rd, input int rs1, input int rs2,
                          input int f3, input int f7, input int imm);
    in_class  = 3'(cls);
    in_rd     = 5'(rd);
    in_rs1    = 5'(rs1);
    in_rs2    = 5'(rs2);
    in_funct3 = 3'(f3);
    in_funct7 = 7'(f7);
    in_imm    = imm;
  endtask

  task automatic push(input int cls, input int rd, input int rs1, input int rs2,
                      input int f3, input int f7, input int imm);
    int n;
    set_desc(cls, rd, rs1, rs2, f3, f7, imm);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (n == 100) check("push_timeout", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  function automatic int rand_imm();
    int edges[10] = '{2047, -2048, 2048, -2049, 4094, -4096, 4096, 1048574, -1048576, 1048576};
    case ($urandom_range(0, 4))
      0:       return int'($urandom);
      1:       return int'($urandom_range(0, 4095)) - 2048;
      2:       return (int'($urandom_range(0, 4095)) - 2048) * 2;
      3:       return (int'($urandom_range(0, 1048575)) - 524288) * 2;
      default: return edges[$urandom_range(0, 9)];
    endcase
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] words[5];
    bit          b;
    int          n;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_desc(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_count", {29'b0, count}, 32'd0);
    check("rst_out_addr", {30'b0, out_addr}, 32'd0);
    check("rst_err_pulse", {31'b0, err_pulse}, 32'd0);
    check("rst_err_sticky", {31'b0, err_sticky}, 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // ADD x3,x1,x2 : one-cycle latency to output
    out_ready = 1'b1;
    set_desc(0, 3, 1, 2, 0, 0, 0);
    in_valid = 1'b1;
    check("add_pre_valid", {31'b0, out_valid}, 32'd0);
    tick();
    in_valid = 1'b0;
    check("add_valid", {31'b0, out_valid}, 32'd1);
    check("add_instr", out_instr, 32'h002081B3);
    check("add_addr", {30'b0, out_addr}, 32'd0);

    push(4, 5, 0, 0, 0, 0, -1);
    check("addi_instr", out_instr, 32'hFFF00293);
    check("addi_addr", {30'b0, out_addr}, 32'd1);
    push(2, 0, 1, 2, 2, 0, 8);
    check("sw_instr", out_instr, 32'h0020A423);
    check("sw_addr", {30'b0, out_addr}, 32'd2);
    push(3, 0, 1, 2, 0, 0, -4);
    check("beq_instr", out_instr, 32'hFE208EE3);
    push(5, 1, 0, 0, 0, 0, 8);
    check("jal_instr", out_instr, 32'h008000EF);
    check("jal_addr_wrap", {30'b0, out_addr}, 32'd0);
    tick();

    // Rejections: misaligned branch offset, then illegal class
    push(3, 0, 1, 2, 0, 0, 3);
    check("bimm_err_pulse", {31'b0, err_pulse}, 32'd1);
    check("bimm_count", {29'b0, count}, 32'd0);
    check("bimm_out_valid", {31'b0, out_valid}, 32'd0);
    tick();
    check("bimm_pulse_end", {31'b0, err_pulse}, 32'd0);
    check("bimm_sticky", {31'b0, err_sticky}, 32'd1);
    push(7, 1, 1, 1, 0, 0, 0);
    check("ill_err_pulse", {31'b0, err_pulse}, 32'd1);
    check("ill_count", {29'b0, count}, 32'd0);
    check("ill_addr", {30'b0, out_addr}, 32'd1);
    tick();
    check("ill_pulse_end", {31'b0, err_pulse}, 32'd0);

    // Reset mid-operation flushes queued words
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(4, i + 1, 0, 0, 0, 0, i);
    check("flush_pre_count", {29'b0, count}, 32'd3);
    rst = 1'b1;
    tick();
    check("flush_count", {29'b0, count}, 32'd0);
    check("flush_out_valid", {31'b0, out_valid}, 32'd0);
    check("flush_out_addr", {30'b0, out_addr}, 32'd0);
    check("flush_err_sticky", {31'b0, err_sticky}, 32'd0);
    check("flush_in_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b0;
    tick();
    check("flush_in_ready_after", {31'b0, in_ready}, 32'd1);

    // Fill to full with the output stalled, then release with a pending push
    for (int i = 0; i < 5; i++) words[i] = ref_enc(4, i + 1, 0, 0, 0, 0, i * 100 + 1, b);
    for (int i = 0; i < 4; i++) push(4, i + 1, 0, 0, 0, 0, i * 100 + 1);
    check("full_count", {29'b0, count}, 32'd4);
    check("full_in_ready", {31'b0, in_ready}, 32'd0);
    check("full_head_instr", out_instr, 32'h00100093);
    check("full_head_addr", {30'b0, out_addr}, 32'd0);
    set_desc(4, 5, 0, 0, 0, 0, 401);
    in_valid = 1'b1;
    tick();
    tick();
    check("full_stall_in_ready", {31'b0, in_ready}, 32'd0);
    check("full_stall_instr", out_instr, words[0]);
    check("full_stall_count", {29'b0, count}, 32'd4);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("drain_instr", out_instr, words[k]);
      check("drain_addr", {30'b0, out_addr}, k % 4);
      if (k == 1) begin
        check("reopen_in_ready", {31'b0, in_ready}, 32'd1);
        check("reopen_count", {29'b0, count}, 32'd3);
      end
      if (k == 2) check("pushpop_count", {29'b0, count}, 32'd3);
      tick();
      if (k == 1) in_valid = 1'b0;
    end
    check("drain_empty", {31'b0, out_valid}, 32'd0);

    // Random traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      set_desc($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
               $urandom_range(0, 31), $urandom_range(0, 7), $urandom_range(0, 127),
               rand_imm());
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (out_valid && n < 20) begin
      tick();
      n++;
    end
    check("final_drain", {31'b0, out_valid}, 32'd0);
    check("final_count", {29'b0, count}, 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
